// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB bridge definitions: transfer codes, control-word layout, error data and
// the APB sequencer state encoding.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE = 2'b00,
        HTRANS_BUSY = 2'b01,
        HTRANS_NSEQ = 2'b10,
        HTRANS_SEQ  = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int CTRL_W         = 41;
    localparam int CTRL_HWRITE    = 40;
    localparam int CTRL_HTRANS_HI = 39;
    localparam int CTRL_HTRANS_LO = 38;
    localparam int CTRL_HBURST_HI = 37;
    localparam int CTRL_HBURST_LO = 35;
    localparam int CTRL_HSIZE_HI  = 34;
    localparam int CTRL_HSIZE_LO  = 32;
    localparam int CTRL_HADDR_HI  = 31;
    localparam int CTRL_HADDR_LO  = 0;

    // Field order mirrors the bit positions above, MSB first.
    typedef struct packed {
        logic        hwrite;
        htrans_e     htrans;
        hburst_e     hburst;
        logic [2:0]  hsize;
        logic [31:0] haddr;
    } ctrl_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    function automatic logic slave_mapped(input int unsigned idx, input int unsigned num_slaves);
        return idx < num_slaves;
    endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// APB bus between the bridge sequencer (master) and its slaves; prdata is packed per slave,
// slave i at [i*DATA_WIDTH +: DATA_WIDTH].
interface apb_master_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    logic [31:0]                      paddr;
    logic [NUM_SLAVES-1:0]            psel;
    logic                             penable;
    logic                             pwrite;
    logic [DATA_WIDTH-1:0]            pwdata;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata;
    logic [NUM_SLAVES-1:0]            pready;
    logic [NUM_SLAVES-1:0]            pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_mux.sv
// Slave index decode: one-hot psel, mapped flag, and selection of the addressed slave's
// prdata/pready/pslverr.
module apb_slave_mux
    import ahb_apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_SEL_W  = 2
) (
    input  logic                             sel_en,
    input  logic [SLV_SEL_W-1:0]             idx,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES-1:0]            pslverr,
    output logic [NUM_SLAVES-1:0]            psel,
    output logic                             valid,
    output logic [DATA_WIDTH-1:0]            sel_rdata,
    output logic                             sel_ready,
    output logic                             sel_slverr
);
    logic [NUM_SLAVES-1:0] hit;

    assign valid = slave_mapped(32'(idx), NUM_SLAVES);

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
            assign hit[gi]  = (idx == SLV_SEL_W'(gi));
            assign psel[gi] = sel_en & hit[gi];
        end
    endgenerate

    // AND-OR return mux: an unmapped index selects nothing and returns zeros.
    always_comb begin
        sel_rdata  = '0;
        sel_ready  = 1'b0;
        sel_slverr = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (hit[i]) begin
                sel_rdata  = prdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_ready  = pready[i];
                sel_slverr = pslverr[i];
            end
        end
    end
endmodule

// File: rtl/apb_master_ctrl.sv
// APB-side sequencer of the AHB-APB bridge: pops control/write-data FIFOs, runs SETUP/ACCESS,
// pushes read data. Optional ACCESS wait limit enabled by defining APB_TIMEOUT_EN.
module apb_master_ctrl
    import ahb_apb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SLV_SEL_LSB    = 12,
    parameter int SLV_SEL_W      = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   hclk,
    input  logic                   resetn,
    input  logic                   ctrl_empty,
    input  logic [CTRL_W-1:0]      ctrl_rdata,
    output logic                   ctrl_ren,
    input  logic                   ahb_data_empty,
    input  logic [DATA_WIDTH-1:0]  ahb_data_rdata,
    output logic                   ahb_data_ren,
    input  logic                   apb_data_full,
    output logic                   apb_data_wen,
    output logic [DATA_WIDTH-1:0]  apb_data_wdata,
    apb_master_ctrl_if.master      apb,
    output logic                   apb_err
);
    apb_state_e            state_reg, state_next;
    logic [SLV_SEL_W-1:0]  idx_reg, idx_next;
    logic [31:0]           paddr_reg, paddr_next;
    logic                  pwrite_reg, pwrite_next;
    logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;

    ctrl_t                 head;
    logic                  is_xfer, eligible, launch_mapped, do_launch;
    logic [SLV_SEL_W-1:0]  launch_idx;
    logic                  ctrl_ren_c, data_ren_c, wen_c, err_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic                  cur_valid, sel_ready, sel_slverr, tmo_hit;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  unused_fields;

    assign head          = ctrl_t'(ctrl_rdata);
    assign unused_fields = ^{head.hburst, head.hsize, head.htrans[0]};
    assign is_xfer       = head.htrans[1];
    assign launch_idx    = head.haddr[SLV_SEL_LSB +: SLV_SEL_W];
    assign launch_mapped = slave_mapped(32'(launch_idx), NUM_SLAVES);
    // IDLE/BUSY entries are always poppable; real transfers need their data path ready.
    assign eligible = !ctrl_empty &&
                      (!is_xfer || (head.hwrite ? !ahb_data_empty : !apb_data_full));

    apb_slave_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_SEL_W  (SLV_SEL_W)
    ) u_mux (
        .sel_en     ((state_reg != ST_IDLE) && cur_valid),
        .idx        (idx_reg),
        .prdata     (apb.prdata),
        .pready     (apb.pready),
        .pslverr    (apb.pslverr),
        .psel       (apb.psel),
        .valid      (cur_valid),
        .sel_rdata  (sel_rdata),
        .sel_ready  (sel_ready),
        .sel_slverr (sel_slverr)
    );

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;

    always_comb begin
        tmo_cnt_next = tmo_cnt_reg;
        if (do_launch)
            tmo_cnt_next = '0;
        else if (state_reg == ST_ACCESS && !sel_ready)
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
    end

    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) tmo_cnt_reg <= '0;
        else         tmo_cnt_reg <= tmo_cnt_next;
    end

    // Hit on the last allowed waiting cycle; a pready in that cycle still completes normally.
    assign tmo_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        paddr_next  = paddr_reg;
        pwrite_next = pwrite_reg;
        pwdata_next = pwdata_reg;
        do_launch   = 1'b0;
        ctrl_ren_c  = 1'b0;
        data_ren_c  = 1'b0;
        wen_c       = 1'b0;
        wdata_c     = '0;
        err_c       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (eligible) begin
                    if (!is_xfer) begin
                        ctrl_ren_c = 1'b1;
                    end else if (launch_mapped) begin
                        do_launch = 1'b1;
                    end else begin
                        ctrl_ren_c = 1'b1;
                        data_ren_c = head.hwrite;
                        err_c      = 1'b1;
                        if (!head.hwrite) begin
                            wen_c   = 1'b1;
                            wdata_c = DATA_WIDTH'(ERR_DATA);
                        end
                    end
                end
            end
            ST_SETUP: state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_ready) begin
                    if (!pwrite_reg) begin
                        wen_c   = 1'b1;
                        wdata_c = sel_rdata;
                    end
                    err_c = sel_slverr;
                    if (eligible && is_xfer && launch_mapped) do_launch = 1'b1;
                    else                                        state_next = ST_IDLE;
                end else if (tmo_hit) begin
                    err_c = 1'b1;
                    if (!pwrite_reg) begin
                        wen_c   = 1'b1;
                        wdata_c = DATA_WIDTH'(ERR_DATA);
                    end
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (do_launch) begin
            ctrl_ren_c  = 1'b1;
            data_ren_c  = head.hwrite;
            idx_next    = launch_idx;
            paddr_next  = head.haddr;
            pwrite_next = head.hwrite;
            pwdata_next = head.hwrite ? ahb_data_rdata : pwdata_reg;
            state_next  = ST_SETUP;
        end
    end

    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
            paddr_reg  <= '0;
            pwrite_reg <= 1'b0;
            pwdata_reg <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            paddr_reg  <= paddr_next;
            pwrite_reg <= pwrite_next;
            pwdata_reg <= pwdata_next;
        end
    end

    // Strobes are masked by reset so nothing pops or pushes while resetn is held low.
    assign ctrl_ren       = resetn & ctrl_ren_c;
    assign ahb_data_ren   = resetn & data_ren_c;
    assign apb_data_wen   = resetn & wen_c;
    assign apb_data_wdata = resetn ? wdata_c : '0;
    assign apb_err        = resetn & err_c;

    assign apb.paddr   = paddr_reg;
    assign apb.penable = (state_reg == ST_ACCESS);
    assign apb.pwrite  = pwrite_reg;
    assign apb.pwdata  = pwdata_reg;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with three mapped slaves (index 3 unmapped).
module tb_apb_master_ctrl;
    import ahb_apb_pkg::*;

    localparam int DW = 32;
    localparam int NS = 3;

    logic          hclk = 1'b0;
    logic          resetn;
    logic          ctrl_empty;
    logic [40:0]   ctrl_rdata;
    logic          ctrl_ren;
    logic          ahb_data_empty;
    logic [DW-1:0] ahb_data_rdata;
    logic          ahb_data_ren;
    logic          apb_data_full;
    logic          apb_data_wen;
    logic [DW-1:0] apb_data_wdata;
    logic          apb_err;

    int n_cmp  = 0;
    int n_fail = 0;

    apb_master_ctrl_if #(.DATA_WIDTH(DW), .NUM_SLAVES(NS)) apb ();

    apb_master_ctrl #(
        .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLV_SEL_LSB(12), .SLV_SEL_W(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .hclk           (hclk),
        .resetn         (resetn),
        .ctrl_empty     (ctrl_empty),
        .ctrl_rdata     (ctrl_rdata),
        .ctrl_ren       (ctrl_ren),
        .ahb_data_empty (ahb_data_empty),
        .ahb_data_rdata (ahb_data_rdata),
        .ahb_data_ren   (ahb_data_ren),
        .apb_data_full  (apb_data_full),
        .apb_data_wen   (apb_data_wen),
        .apb_data_wdata (apb_data_wdata),
        .apb            (apb),
        .apb_err        (apb_err)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    function automatic logic [40:0] mk(input logic w, input logic [1:0] tr,
                                       input logic [2:0] hb, input logic [31:0] a);
        return {w, tr, hb, HSIZE_WORD, a};
    endfunction

    task automatic set_prdata(input int i, input logic [DW-1:0] v);
        apb.prdata[i*DW +: DW] = v;
    endtask

    initial begin
        logic [40:0] q [4];

        // Reset with a valid entry waiting: nothing may pop, all outputs zero
        resetn = 1'b0; ctrl_empty = 1'b0; ctrl_rdata = mk(1'b1, 2'b10, 3'd0, 32'h1004);
        ahb_data_empty = 1'b0; ahb_data_rdata = 32'h1111_2222; apb_data_full = 1'b0;
        apb.prdata = '0; apb.pready = '0; apb.pslverr = '0;
        #2;
        chk("rst_psel", 64'(apb.psel), 64'h0);
        chk("rst_penable", 64'(apb.penable), 64'h0);
        chk("rst_paddr", 64'(apb.paddr), 64'h0);
        chk("rst_pwdata", 64'(apb.pwdata), 64'h0);
        chk("rst_ctrl_ren", 64'(ctrl_ren), 64'h0);
        chk("rst_data_ren", 64'(ahb_data_ren), 64'h0);
        chk("rst_wen_err", 64'({apb_data_wen, apb_err}), 64'h0);
        chk("rst_wdata", 64'(apb_data_wdata), 64'h0);
        ctrl_empty = 1'b1; ahb_data_empty = 1'b1;
        @(negedge hclk); resetn = 1'b1;
        step();
        $display("T0 reset done");

        // T1: single write to slave 1
        apb.pready = 3'b111;
        ctrl_rdata = mk(1'b1, 2'b10, 3'd0, 32'h0000_1004); ctrl_empty = 1'b0;
        ahb_data_rdata = 32'hA5A5_0001; ahb_data_empty = 1'b0;
        #1;
        chk("t1_ctrl_ren", 64'(ctrl_ren), 64'h1);
        chk("t1_data_ren", 64'(ahb_data_ren), 64'h1);
        step(); ctrl_empty = 1'b1; ahb_data_empty = 1'b1; #1;
        chk("t1_setup_psel", 64'(apb.psel), 64'b010);
        chk("t1_setup_penable", 64'(apb.penable), 64'h0);
        chk("t1_paddr", 64'(apb.paddr), 64'h1004);
        chk("t1_pwdata", 64'(apb.pwdata), 64'hA5A5_0001);
        chk("t1_pwrite", 64'(apb.pwrite), 64'h1);
        chk("t1_no_pop", 64'({ctrl_ren, ahb_data_ren}), 64'h0);
        step();
        chk("t1_access_psel", 64'(apb.psel), 64'b010);
        chk("t1_access_penable", 64'(apb.penable), 64'h1);
        chk("t1_access_pwdata", 64'(apb.pwdata), 64'hA5A5_0001);
        chk("t1_no_push", 64'({apb_data_wen, apb_err}), 64'h0);
        step();
        chk("t1_idle_psel", 64'({apb.psel, apb.penable}), 64'h0);
        chk("t1_hold_paddr", 64'(apb.paddr), 64'h1004);
        $display("T1 write idx1 done");

        // T2: read from slave 2 with three wait states
        apb.pready = '0; set_prdata(1, 32'hBAD0_0001); set_prdata(2, 32'h1234_5678);
        ctrl_rdata = mk(1'b0, 2'b10, 3'd0, 32'h0000_2008); ctrl_empty = 1'b0;
        #1;
        chk("t2_ctrl_ren", 64'(ctrl_ren), 64'h1);
        chk("t2_data_ren", 64'(ahb_data_ren), 64'h0);
        step(); ctrl_empty = 1'b1; #1;
        chk("t2_setup", 64'({apb.psel, apb.penable, apb.pwrite}), 64'b100_0_0);
        chk("t2_paddr", 64'(apb.paddr), 64'h2008);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t2_wait", 64'({apb.psel, apb.penable, apb_data_wen}), 64'b100_1_0);
            step();
        end
        apb.pready = 3'b100; #1;
        chk("t2_done_penable", 64'(apb.penable), 64'h1);
        chk("t2_wen", 64'(apb_data_wen), 64'h1);
        chk("t2_wdata", 64'(apb_data_wdata), 64'h1234_5678);
        step();
        chk("t2_idle", 64'({apb.psel, apb.penable, apb_data_wen}), 64'h0);
        $display("T2 read idx2 with waits done");

        // T3: four queued INCR4 writes to slave 0, back to back
        apb.pready = 3'b111;
        for (int k = 0; k < 4; k++)
            q[k] = mk(1'b1, (k == 0) ? 2'b10 : 2'b11, 3'd3, 32'(4 * k));
        ctrl_rdata = q[0]; ctrl_empty = 1'b0;
        ahb_data_rdata = 32'hC0DE_0000; ahb_data_empty = 1'b0;
        #1;
        chk("t3_launch_pop", 64'({ctrl_ren, ahb_data_ren}), 64'b11);
        step();
        for (int c = 0; c < 8; c++) begin
            int k;
            k = c / 2 + 1;
            if (k < 4) begin
                ctrl_rdata = q[k]; ctrl_empty = 1'b0;
                ahb_data_rdata = 32'hC0DE_0000 + 32'(k); ahb_data_empty = 1'b0;
            end else begin
                ctrl_empty = 1'b1; ahb_data_empty = 1'b1;
            end
            #1;
            chk("t3_psel", 64'(apb.psel), 64'b001);
            chk("t3_penable", 64'(apb.penable), 64'(c % 2));
            chk("t3_paddr", 64'(apb.paddr), 64'(4 * (c / 2)));
            chk("t3_pwdata", 64'(apb.pwdata), 64'(32'hC0DE_0000 + 32'(c / 2)));
            chk("t3_pop", 64'({ctrl_ren, ahb_data_ren}), ((c % 2 == 1) && c < 7) ? 64'b11 : 64'b00);
            step();
        end
        chk("t3_idle", 64'({apb.psel, apb.penable}), 64'h0);
        $display("T3 four back-to-back writes done");

        // T4a: read blocked while the read-data FIFO is full
        apb_data_full = 1'b1; set_prdata(0, 32'h0BAD_F00D);
        ctrl_rdata = mk(1'b0, 2'b10, 3'd0, 32'h0000_0010); ctrl_empty = 1'b0;
        #1;
        chk("t4_full_no_pop", 64'(ctrl_ren), 64'h0);
        step();
        chk("t4_full_psel", 64'(apb.psel), 64'h0);
        apb_data_full = 1'b0; #1;
        chk("t4_unfull_pop", 64'(ctrl_ren), 64'h1);
        step(); ctrl_empty = 1'b1; #1;
        chk("t4_setup_psel", 64'(apb.psel), 64'b001);
        step();
        chk("t4_read_push", 64'({apb_data_wen, apb_data_wdata}), {31'h0, 1'b1, 32'h0BAD_F00D});
        step();

        // T4b: unmapped read and write (index 3)
        ctrl_rdata = mk(1'b0, 2'b10, 3'd0, 32'h0000_3000); ctrl_empty = 1'b0;
        #1;
        chk("t4_unm_rd_pop", 64'({ctrl_ren, ahb_data_ren}), 64'b10);
        chk("t4_unm_rd_err", 64'(apb_err), 64'h1);
        chk("t4_unm_rd_push", 64'({apb_data_wen, apb_data_wdata}), {31'h0, 1'b1, 32'hDEAD_BEEF});
        chk("t4_unm_rd_psel", 64'(apb.psel), 64'h0);
        step();
        chk("t4_unm_rd_stay", 64'({apb.psel, apb.penable}), 64'h0);
        ctrl_rdata = mk(1'b1, 2'b10, 3'd0, 32'h0000_3004);
        ahb_data_rdata = 32'h5555_AAAA; ahb_data_empty = 1'b0;
        #1;
        chk("t4_unm_wr_pop", 64'({ctrl_ren, ahb_data_ren}), 64'b11);
        chk("t4_unm_wr_err", 64'({apb_err, apb_data_wen}), 64'b10);
        step(); ahb_data_empty = 1'b1;

        // T4c: htrans IDLE entry is discarded without touching write data
        ctrl_rdata = mk(1'b1, 2'b00, 3'd0, 32'h0000_1000);
        #1;
        chk("t4_discard_pop", 64'({ctrl_ren, ahb_data_ren, apb_err}), 64'b100);
        step(); ctrl_empty = 1'b1; #1;
        chk("t4_discard_idle", 64'(apb.psel), 64'h0);
        chk("t4_hold_paddr", 64'(apb.paddr), 64'h0000_0010);
        $display("T4 full/unmapped/discard done");

        // T5a: pslverr on write completion
        apb.pready = 3'b111; apb.pslverr = 3'b001;
        ctrl_rdata = mk(1'b1, 2'b10, 3'd0, 32'h0000_0020); ctrl_empty = 1'b0;
        ahb_data_rdata = 32'h7777_0000; ahb_data_empty = 1'b0;
        step(); ctrl_empty = 1'b1; ahb_data_empty = 1'b1; #1;
        chk("t5_setup_noerr", 64'(apb_err), 64'h0);
        step();
        chk("t5_slverr", 64'({apb_err, apb.penable}), 64'b11);
        step();
        chk("t5_err_pulse", 64'(apb_err), 64'h0);
        apb.pslverr = '0;

        // T5b: reset asserted in the middle of ACCESS
        apb.pready = '0;
        ctrl_rdata = mk(1'b0, 2'b10, 3'd0, 32'h0000_1040); ctrl_empty = 1'b0;
        step(); ctrl_empty = 1'b1;
        step();
        chk("t5_in_access", 64'({apb.psel, apb.penable}), 64'b010_1);
        resetn = 1'b0; #1;
        chk("t5_rst_bus", 64'({apb.psel, apb.penable, apb.pwrite}), 64'h0);
        chk("t5_rst_paddr", 64'(apb.paddr), 64'h0);
        chk("t5_rst_pwdata", 64'(apb.pwdata), 64'h0);
        step();
        @(negedge hclk); resetn = 1'b1;
        apb.pready = 3'b010;
        step();
        chk("t5_after_rst", 64'({apb.psel, apb.penable, apb_data_wen}), 64'h0);
        $display("T5 pslverr and reset-in-ACCESS done");

`ifdef APB_TIMEOUT_EN
        // T6: slave never ready -> abort on the 16th ACCESS cycle
        apb.pready = '0;
        ctrl_rdata = mk(1'b0, 2'b10, 3'd0, 32'h0000_0000); ctrl_empty = 1'b0;
        step(); ctrl_empty = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            chk("t6_waiting", 64'({apb.penable, apb_err, apb_data_wen}), 64'b100);
            step();
        end
        chk("t6_abort", 64'({apb.penable, apb_err, apb_data_wen}), 64'b111);
        chk("t6_err_data", 64'(apb_data_wdata), 64'hDEAD_BEEF);
        step();
        chk("t6_idle", 64'({apb.psel, apb.penable, apb_err}), 64'h0);
        $display("T6 timeout abort done");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
